// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment glyphs, FSM states and double-dabble helper for seg7_bin2bcd
package seg7_pkg;
  localparam logic [7:0] SEG_A = 8'h01;
  localparam logic [7:0] SEG_B = 8'h02;
  localparam logic [7:0] SEG_C = 8'h04;
  localparam logic [7:0] SEG_D = 8'h08;
  localparam logic [7:0] SEG_E = 8'h10;
  localparam logic [7:0] SEG_F = 8'h20;
  localparam logic [7:0] SEG_G = 8'h40;
  localparam int BCD_MAX = 9999;
  localparam logic [7:0] SEG_TABLE [16] = '{
    SEG_A|SEG_B|SEG_C|SEG_D|SEG_E|SEG_F,
    SEG_B|SEG_C,
    SEG_A|SEG_B|SEG_D|SEG_E|SEG_G,
    SEG_A|SEG_B|SEG_C|SEG_D|SEG_G,
    SEG_B|SEG_C|SEG_F|SEG_G,
    SEG_A|SEG_C|SEG_D|SEG_F|SEG_G,
    SEG_A|SEG_C|SEG_D|SEG_E|SEG_F|SEG_G,
    SEG_A|SEG_B|SEG_C,
    SEG_A|SEG_B|SEG_C|SEG_D|SEG_E|SEG_F|SEG_G,
    SEG_A|SEG_B|SEG_C|SEG_D|SEG_F|SEG_G,
    SEG_A|SEG_B|SEG_C|SEG_E|SEG_F|SEG_G,
    SEG_C|SEG_D|SEG_E|SEG_F|SEG_G,
    SEG_A|SEG_D|SEG_E|SEG_F,
    SEG_B|SEG_C|SEG_D|SEG_E|SEG_G,
    SEG_A|SEG_D|SEG_E|SEG_F|SEG_G,
    SEG_A|SEG_E|SEG_F|SEG_G
  };
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_t;
  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++)
      if (r[4*i+:4] >= 4'd5) r[4*i+:4] = r[4*i+:4] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/seg7_hex2seg.sv
// seg7_hex2seg: combinational 4-bit to active-high 7-segment encoder
module seg7_hex2seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: iterative double-dabble binary-to-BCD; leading-zero-blanked segments under SEG7_BIN2BCD_LZB_EN
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             ovf,
  output logic [31:0]      pixels,
  output logic             direct
);
  state_t state;
  logic [WIDTH-1:0] sh;
  logic [19:0] scr;
  logic over;
  logic [4:0] cnt;
  logic [15:0] res;
  assign res = over ? 16'h9999 : scr[15:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sh <= '0;
      scr <= '0;
      over <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          sh <= bin;
          scr <= '0;
          over <= 32'(bin) > BCD_MAX;
          cnt <= '0;
          busy <= 1'b1;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {scr, sh} <= {add3(scr), sh} << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(WIDTH - 1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          bcd <= res;
          ovf <= over;
          done <= 1'b1;
          busy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef SEG7_BIN2BCD_LZB_EN
  logic [7:0] seg [4];
  logic [31:0] pix_n;
  for (genvar d = 0; d < 4; d++) begin : g_enc
    seg7_hex2seg u_enc (.hex(res[4*d+:4]), .seg(seg[d]));
  end
  // units byte sits at the top so it lands on the driver's rightmost digit
  assign pix_n = {seg[0],
                  res[15:4] == 12'h0 ? 8'h00 : seg[1],
                  res[15:8] == 8'h0  ? 8'h00 : seg[2],
                  res[15:12] == 4'h0 ? 8'h00 : seg[3]};
  always_ff @(posedge clk) begin
    if (reset) begin
      pixels <= '0;
      direct <= 1'b0;
    end else if (state == ST_FINISH) begin
      pixels <= pix_n;
      direct <= 1'b1;
    end
  end
`else
  assign pixels = '0;
  assign direct = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_bin2bcd.sv
// tb_seg7_bin2bcd: directed bench with a decimal-arithmetic reference model checked every cycle
module tb_seg7_bin2bcd;
  localparam int W = 14;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [W-1:0] bin = '0;
  logic [15:0] bin2 = '0;
  logic busy, done, ovf, direct, busy2, done2, ovf2, direct2;
  logic [15:0] bcd, bcd2;
  logic [31:0] pixels, pixels2;
  int checks = 0, errors = 0;
  bit mon = 1'b0;
  always #5 clk = ~clk;

  seg7_bin2bcd #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .pixels(pixels), .direct(direct));
  seg7_bin2bcd #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2), .pixels(pixels2), .direct(direct2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] exp_pix(input int v);
    logic [7:0] glyph [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [31:0] p = '0;
    int s = v > 9999 ? 9999 : v;
    int pw = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || s >= pw) p[31-8*i -: 8] = glyph[(s / pw) % 10];
      pw *= 10;
    end
    return p;
  endfunction

  // reference model: fixed-latency transaction timing plus decimal arithmetic
  int m_rem = 0, m_val = 0;
  logic m_busy = 0, m_done = 0, m_ovf = 0, m_dir = 0;
  logic [15:0] m_bcd = '0;
  logic [31:0] m_pix = '0;
  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_bcd = '0; m_ovf = 0; m_pix = '0; m_dir = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_bcd = exp_bcd(m_val); m_ovf = m_val > 9999;
`ifdef SEG7_BIN2BCD_LZB_EN
          m_pix = exp_pix(m_val); m_dir = 1;
`endif
        end
      end else if (start) begin
        m_val = int'(bin); m_rem = W + 1; m_busy = 1;
      end
    end
  end

  always @(negedge clk) if (mon) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("bcd", 32'(bcd), 32'(m_bcd));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("pixels", pixels, m_pix);
    chk("direct", 32'(direct), 32'(m_dir));
  end

  task automatic go(input int v, output int lat, output int bc);
    start = 1'b1; bin = W'(v); lat = 0; bc = 0;
    while (lat < 60) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bc++;
      if (done) break;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int lat, bc, nd;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_pix", pixels, 32'h0);
    reset = 1'b0;
    mon = 1'b1;
    go(1234, lat, bc);
    chk("lat_1234", 32'(lat - 1), 32'd15);
    chk("busy_cycles", 32'(bc), 32'd15);
    chk("bcd_1234", 32'(bcd), 32'h1234);
    go(9999, lat, bc);
    chk("bcd_9999", 32'(bcd), 32'h9999);
    chk("ovf_9999", 32'(ovf), 32'd0);
    go(10000, lat, bc);
    chk("bcd_10000", 32'(bcd), 32'h9999);
    chk("ovf_10000", 32'(ovf), 32'd1);
    @(negedge clk);
    start = 1'b1; bin = W'(42); nd = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done) nd++;
      start = (i == 2 || i == 14);
      bin = (i == 2 || i == 14) ? W'(7) : W'(42);
    end
    chk("busy_ignore_done_cnt", 32'(nd), 32'd1);
    chk("bcd_42", 32'(bcd), 32'h0042);
    go(7, lat, bc);
    chk("bcd_7", 32'(bcd), 32'h0007);
`ifdef SEG7_BIN2BCD_LZB_EN
    chk("pix_7", pixels, 32'h07000000);
    chk("direct_on", 32'(direct), 32'd1);
`else
    chk("pix_tied", pixels, 32'h0);
`endif
    go(0, lat, bc);
    chk("bcd_0", 32'(bcd), 32'h0000);
`ifdef SEG7_BIN2BCD_LZB_EN
    chk("pix_0", pixels, 32'h3F000000);
`endif
    go(321, lat, bc);
    chk("bcd_321", 32'(bcd), 32'h0321);
    start = 1'b1; bin = W'(5678);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) reset = 1'b1;
    end
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h0000);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    start2 = 1'b1; bin2 = 16'd65535; lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      start2 = 1'b0;
      lat++;
      if (done2) break;
    end
    chk("w16_lat", 32'(lat - 1), 32'd17);
    chk("w16_bcd", 32'(bcd2), 32'h9999);
    chk("w16_ovf", 32'(ovf2), 32'd1);
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
